// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads the combinational instruction memory and holds the
// fetched word in a valid/ready register toward decode. Illegal redirects halt until reset.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] AddrMask  = 32'(IMEM_BYTES - 1);
  localparam logic [31:0] ImemLimit = 32'(IMEM_BYTES);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic        slot_free;
  logic        redirect_illegal;

  assign imem_addr        = pc_q;
  assign pc_plus4         = pc_q + 32'd4;
  assign slot_free        = !id_valid || id_ready;
  assign redirect_illegal = redirect_valid &&
                            ((redirect_target[1:0] != 2'b00) || (redirect_target >= ImemLimit));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= 32'h0;
      id_pc       <= 32'h0;
      id_pc_plus4 <= 32'h0;
      fault       <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: state_q <= StRun;
        StRun: begin
          if (redirect_illegal) begin
            state_q  <= StHalt;
            fault    <= 1'b1;
            id_valid <= 1'b0;
          end else if (redirect_valid) begin
            // Any held instruction is squashed, even one stalled by decode.
            pc_q     <= redirect_target;
            id_valid <= 1'b0;
          end else if (slot_free) begin
            id_instr    <= imem_rdata;
            id_pc       <= pc_q;
            id_pc_plus4 <= pc_plus4;
            id_valid    <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
            pc_q        <= pc_plus4 & AddrMask;
          end
        end
        StHalt: id_valid <= 1'b0;
        default: state_q <= StHalt;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Program-counter and fetch stage that sits directly upstream of the instruction memory: it drives the byte read address, captures the returned instruction word, and presents it to decode through a valid/ready register. It applies branch/jump redirects from execute and halts on an illegal target. The instruction memory read is combinational, so one instruction is fetched per cycle when decode accepts.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- IMEM_BYTES, 256: instruction-memory size in bytes, a power of two and ≥ 8. Legal PCs are 0 .. IMEM_BYTES-4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- imem_addr  out  32  byte read address to instruction memory; always equals the internal PC.
- imem_rdata  in  32  instruction word returned combinationally for imem_addr.
- redirect_valid  in  1  execute requests a PC change (taken branch, jal, jalr).
- redirect_target  in  32  new byte PC; sampled only when redirect_valid=1.
- id_ready  in  1  decode can accept the output register this cycle.
- id_valid  out  1  id_instr/id_pc/id_pc_plus4 hold a valid fetched instruction.
- id_instr  out  32  fetched instruction.
- id_pc  out  32  byte address of id_instr.
- id_pc_plus4  out  32  id_pc + 4, modulo 2^32.
- fault  out  1  sticky illegal-redirect flag.
- fetch_count  out  32  number of instructions captured into the output register.

## Operation
- States: IDLE, RUN, HALT.
  - IDLE is entered on reset and lasts exactly one cycle after reset deasserts. No capture occurs in IDLE. The next state is RUN.
  - RUN is the normal fetch state.
  - HALT is entered on an illegal redirect. It is left only through reset.
- Reset values: pc=RESET_PC, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0, fault=0, fetch_count=0, state=IDLE.
- Free slot: slot_free = !id_valid | id_ready.
- Priority in RUN, evaluated at each rising edge:
  1. Illegal redirect: redirect_valid=1 and (redirect_target[1:0]≠0 or redirect_target ≥ IMEM_BYTES). Result: state←HALT, fault←1, id_valid←0. The PC is unchanged.
  2. Legal redirect: pc←redirect_target, id_valid←0. Any held instruction is discarded, including one that is stalled with id_ready=0. No capture occurs this edge.
  3. Capture: if slot_free, then id_instr←imem_rdata, id_pc←pc, id_pc_plus4←pc+4, id_valid←1, fetch_count←fetch_count+1 (wraps at 2^32). The PC advances with pc←(pc+4) mod IMEM_BYTES, so it wraps from IMEM_BYTES-4 to 0.
  4. Stall: if !slot_free, all registers hold and the PC does not advance.
- In RUN, if slot_free=0 the output register is held, and id_valid stays at 1.
- In HALT:
  - id_valid is forced to 0.
  - The PC, fetch_count and id_* data hold their values.
  - redirect_valid and id_ready are ignored.
- A handshake (id_valid & id_ready) in the same cycle as a legal redirect counts as consumed by decode. The redirect still clears id_valid.

## Timing
- imem_addr is a register output with no combinational path from any input.
- Fetch latency: an instruction at PC p is visible on id_* in the cycle after the edge that captures it. Throughput is 1 per cycle while id_ready=1.
- First instruction after reset release: deassert reset before edge E0. E0 ends IDLE. E1 captures RESET_PC, so id_valid=1 after E1.
- Redirect bubble: redirect at edge E sets id_valid=0 for exactly one cycle. The target instruction is captured at E+1, provided no fault occurs.
- Asynchronous reset assertion at any point, including HALT or mid-stall, returns all outputs to their reset values immediately, without waiting for a clock edge.

## Test plan
- Reset then sequential fetch: RESET_PC=0, id_ready=1, memory word[i]=i. Required: id_pc sequence 0,4,8,… with id_instr matching, first id_valid one edge after IDLE, fetch_count=5 after 5 captures.
- Backpressure: hold id_ready=0 for 3 cycles while id_valid=1 at id_pc=8. Required: id_pc stays at 8, imem_addr stays at 12, fetch_count is unchanged; capture resumes at 12 after id_ready returns to 1.
- Redirect while stalled: id_pc=16, id_ready=0, redirect to 0x40. Required: id_valid=0 for one cycle, then id_pc=0x40 and id_pc_plus4=0x44.
- Wrap: IMEM_BYTES=256, sequential fetch through PC 252. Required: id_pc=252, then id_pc=0 next capture.
- Illegal redirect: target 0x42 (misaligned), and separately 0x100 with IMEM_BYTES=256. Required: fault=1, id_valid=0, PC and fetch_count frozen for 10 cycles despite id_ready=1 and further redirects.
- Reset during HALT: assert reset=0 mid-cycle. Required: fault=0 and imem_addr=RESET_PC immediately, then normal fetch after release.
